// File: rtl/mem_wb_stage.sv
// Memory and write-back stages: data-memory access with configurable wait states,
// upstream freeze while an access is in flight, and the MEM/WB register.
module mem_wb_stage #(
    parameter int unsigned ADDR_OFFSET = 1024,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned MEM_WAIT    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_en_in,
    input  logic        mem_read_en_in,
    input  logic        mem_write_en_in,
    input  logic [31:0] alu_res_in,
    input  logic [31:0] val_rm_in,
    input  logic [3:0]  dest_in,
    output logic        mem_stall,
    output logic        wb_en_out,
    output logic [3:0]  wb_dest,
    output logic [31:0] wb_value
);

    localparam int unsigned CntW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT + 1) : 1;
    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [31:0]       mem [DEPTH];
    logic [31:0]       offset;
    logic              in_range;
    logic [IdxW-1:0]   idx;
    logic [31:0]       rdata;
    logic              is_write, is_read, mem_op, commit;

    // Byte-address decode; the low two bits are ignored.
    assign offset   = alu_res_in - 32'(ADDR_OFFSET);
    assign in_range = (alu_res_in >= 32'(ADDR_OFFSET)) &&
                      ({2'b00, offset[31:2]} < 32'(DEPTH));
    assign idx      = offset[IdxW+1:2];
    assign rdata    = in_range ? mem[idx] : 32'h0;

    // A request with both enables set behaves as a store.
    assign is_write = mem_write_en_in;
    assign is_read  = mem_read_en_in & ~mem_write_en_in;
    assign mem_op   = mem_read_en_in | mem_write_en_in;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_stall = 1'b0;
        commit    = 1'b0;
        if (MEM_WAIT == 0) begin
            commit = mem_op;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (mem_op) begin
                        mem_stall = 1'b1;
                        state_d   = StWait;
                        cnt_d     = CntW'(MEM_WAIT - 1);
                    end
                end
                StWait: begin
                    if (cnt_q != '0) begin
                        mem_stall = 1'b1;
                        cnt_d     = cnt_q - CntW'(1);
                    end else begin
                        commit  = 1'b1;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
        // Reset must release the freeze immediately and discard any pending store.
        if (!rst) begin
            mem_stall = 1'b0;
            commit    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Memory contents survive reset.
    always_ff @(posedge clk) begin
        if (commit && is_write && in_range) begin
            mem[idx] <= val_rm_in;
        end
    end

    // A stalled cycle inserts a bubble so each instruction writes back once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_en_out <= 1'b0;
            wb_dest   <= 4'h0;
            wb_value  <= 32'h0;
        end else if (mem_stall) begin
            wb_en_out <= 1'b0;
        end else begin
            wb_en_out <= wb_en_in;
            wb_dest   <= dest_in;
            wb_value  <= is_read ? rdata : alu_res_in;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: vector table with a write-back scoreboard,
// plus hand sequences for reset mid-access and zero-wait back-to-back traffic.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_en_in, mem_read_en_in, mem_write_en_in;
    logic [31:0] alu_res_in, val_rm_in;
    logic [3:0]  dest_in;
    logic        mem_stall, wb_en_out;
    logic [3:0]  wb_dest;
    logic [31:0] wb_value;

    logic        z_wb_en_in, z_rd, z_wr;
    logic [31:0] z_alu, z_val;
    logic [3:0]  z_dest_in;
    logic        z_stall, z_wb_en;
    logic [3:0]  z_wb_dest;
    logic [31:0] z_wb_value;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic        wben;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  dest;
        logic [31:0] exp_value;
        int          exp_stall;
    } vec_t;

    typedef struct packed {
        logic [3:0]  dest;
        logic [31:0] value;
    } wb_t;

    vec_t vecs[15];
    wb_t  sb_q[$];

    mem_wb_stage #(.ADDR_OFFSET(1024), .DEPTH(64), .MEM_WAIT(2)) dut (
        .clk(clk), .rst(rst), .wb_en_in(wb_en_in), .mem_read_en_in(mem_read_en_in),
        .mem_write_en_in(mem_write_en_in), .alu_res_in(alu_res_in), .val_rm_in(val_rm_in),
        .dest_in(dest_in), .mem_stall(mem_stall), .wb_en_out(wb_en_out),
        .wb_dest(wb_dest), .wb_value(wb_value)
    );

    mem_wb_stage #(.ADDR_OFFSET(1024), .DEPTH(64), .MEM_WAIT(0)) dut0 (
        .clk(clk), .rst(rst), .wb_en_in(z_wb_en_in), .mem_read_en_in(z_rd),
        .mem_write_en_in(z_wr), .alu_res_in(z_alu), .val_rm_in(z_val),
        .dest_in(z_dest_in), .mem_stall(z_stall), .wb_en_out(z_wb_en),
        .wb_dest(z_wb_dest), .wb_value(z_wb_value)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic wben,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] dest);
        mem_read_en_in  = rd;
        mem_write_en_in = wr;
        wb_en_in        = wben;
        alu_res_in      = addr;
        val_rm_in       = data;
        dest_in         = dest;
    endtask

    task automatic drive_idle();
        drive(1'b0, 1'b0, 1'b0, $urandom, $urandom, 4'($urandom));
    endtask

    task automatic z_drive(input logic rd, input logic wr, input logic wben,
                           input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] dest);
        z_rd       = rd;
        z_wr       = wr;
        z_wb_en_in = wben;
        z_alu      = addr;
        z_val      = data;
        z_dest_in  = dest;
    endtask

    // Entered just after a rising edge; returns just after a rising edge.
    task automatic run_vec(input vec_t v, input int n);
        string tag;
        int    stalls;
        wb_t   e;
        tag = $sformatf("vec%0d", n);
        drive(v.rd, v.wr, v.wben, v.addr, v.data, v.dest);
        if (v.wben) sb_q.push_back({v.dest, v.exp_value});
        stalls = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (!mem_stall) break;
            stalls++;
            check({tag, " bubble during stall"}, 32'(wb_en_out), 32'h0);
            @(posedge clk);
            #1;
        end
        check({tag, " stall cycles"}, 32'(stalls), 32'(v.exp_stall));
        @(posedge clk);
        #1;
        drive_idle();
        @(negedge clk);
        check({tag, " wb_en_out"}, 32'(wb_en_out), 32'(v.wben));
        if (wb_en_out) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s unexpected write-back: got dest %0d, expected none",
                         tag, wb_dest);
            end else begin
                e = sb_q.pop_front();
                check({tag, " wb_dest"}, 32'(wb_dest), 32'(e.dest));
                check({tag, " wb_value"}, wb_value, e.value);
            end
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        check({tag, " single write-back"}, 32'(wb_en_out), 32'h0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 32'h0000002A, 32'h0,         4'd3,  32'h0000002A, 0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'd1028,     32'hDEADBEEF,  4'd0,  32'd1028,     2};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 32'd1028,     32'h0,         4'd5,  32'hDEADBEEF, 2};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'd1024,     32'h11111111,  4'd0,  32'd1024,     2};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 32'd1020,     32'h0,         4'd7,  32'h0,        2};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'd1280,     32'hCAFEF00D,  4'd0,  32'd1280,     2};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 32'd1024,     32'h0,         4'd9,  32'h11111111, 2};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 32'd1027,     32'h0,         4'd2,  32'h11111111, 2};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 32'd1036,     32'h55AA55AA,  4'd4,  32'd1036,     2};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 32'd1036,     32'h0,         4'd6,  32'h55AA55AA, 2};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 32'd1276,     32'h0BADCAFE,  4'd0,  32'd1276,     2};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 32'd1276,     32'h0,         4'd1,  32'h0BADCAFE, 2};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h0,         4'd15, 32'hFFFFFFFF, 0};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 32'd1280,     32'h0,         4'd11, 32'h0,        2};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 32'd1032,     32'h0F0F0F0F,  4'd0,  32'd1032,     2};

        // Reset held with random traffic on both instances.
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom, 4'($urandom));
            z_drive(1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom,
                    4'($urandom));
            @(negedge clk);
            check("reset mem_stall", 32'(mem_stall), 32'h0);
            check("reset wb_en_out", 32'(wb_en_out), 32'h0);
            check("reset wb_dest", 32'(wb_dest), 32'h0);
            check("reset wb_value", wb_value, 32'h0);
            check("reset z mem_stall", 32'(z_stall), 32'h0);
            check("reset z wb_en_out", 32'(z_wb_en), 32'h0);
            @(posedge clk);
            #1;
        end
        drive_idle();
        z_drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int n = 0; n < 15; n++) run_vec(vecs[n], n);

        // Reset dropped mid-store must abandon the write and release the stall at once.
        drive(1'b0, 1'b1, 1'b0, 32'd1032, 32'h12345678, 4'd0);
        @(negedge clk);
        check("abort store stall T", 32'(mem_stall), 32'h1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("abort stall async drop", 32'(mem_stall), 32'h0);
        check("abort wb_en_out", 32'(wb_en_out), 32'h0);
        @(posedge clk);
        #1;
        drive_idle();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        run_vec('{1'b1, 1'b0, 1'b1, 32'd1032, 32'h0, 4'd8, 32'h0F0F0F0F, 2}, 15);

        // Zero-wait instance: store then load back-to-back.
        z_drive(1'b0, 1'b1, 1'b0, 32'd1040, 32'hA5A5A5A5, 4'd0);
        @(negedge clk);
        check("zero-wait store stall", 32'(z_stall), 32'h0);
        @(posedge clk);
        #1;
        z_drive(1'b1, 1'b0, 1'b1, 32'd1040, 32'h0, 4'd10);
        @(negedge clk);
        check("zero-wait load stall", 32'(z_stall), 32'h0);
        check("zero-wait store no wb", 32'(z_wb_en), 32'h0);
        @(posedge clk);
        #1;
        z_drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
        @(negedge clk);
        check("zero-wait wb_en_out", 32'(z_wb_en), 32'h1);
        check("zero-wait wb_dest", 32'(z_wb_dest), 32'd10);
        check("zero-wait wb_value", z_wb_value, 32'hA5A5A5A5);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("zero-wait single wb", 32'(z_wb_en), 32'h0);

        check("scoreboard drained", 32'(sb_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
